// File: rtl/i2s_tx_if.sv
// ---------------------------------------------------------------------------
// i2s_tx_if
// Sample handshake between the effect stage (producer) and the I2S output
// stage (consumer).
//
//   i_data        producer -> consumer  signed sample, stable while valid is high
//   i_data_valid  producer -> consumer  sample available, held until read_done
//   o_read_done   consumer -> producer  sample captured, held until valid drops
//
// modport master : effect stage side (drives data/valid)
// modport slave  : i2s_tx side (drives read_done)
// ---------------------------------------------------------------------------
interface i2s_tx_if #(
  parameter int data_width = 16
);
  logic signed [data_width-1:0] i_data;
  logic                         i_data_valid;
  logic                         o_read_done;

  modport master (
    output i_data,
    output i_data_valid,
    input  o_read_done
  );

  modport slave (
    input  i_data,
    input  i_data_valid,
    output o_read_done
  );
endinterface

// File: rtl/i2s_tx.sv
// ---------------------------------------------------------------------------
// i2s_tx
// Output stage of the audio chain. Accepts mono signed samples over a 4-phase
// valid/read_done handshake, keeps one sample in a holding register, and
// serializes each sample onto both the left and right slots of an I2S frame.
// BCLK and LRCLK are derived from the system clock.
//
// Parameters
//   data_width  sample width and slot width (frame = 2*data_width BCLKs)
//   clk_div     system clocks per BCLK half-period (>= 2)
//
// Ports
//   clk         system clock, everything on its rising edge
//   reset       synchronous, active-high
//   fx          handshake from the effect stage (slave side)
//   o_bclk      I2S bit clock
//   o_lrclk     I2S word select, 0 = left, 1 = right
//   o_sdata     I2S serial data, MSB first, one BCLK after the LRCLK edge
//   o_underrun  one-cycle pulse when a frame loads with nothing held
// ---------------------------------------------------------------------------
module i2s_tx #(
  parameter int data_width = 16,
  parameter int clk_div    = 4
) (
  input  logic      clk,
  input  logic      reset,
  i2s_tx_if.slave   fx,
  output logic      o_bclk,
  output logic      o_lrclk,
  output logic      o_sdata,
  output logic      o_underrun
);

  localparam int FRAME_BITS = 2 * data_width;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam int DIV_W      = $clog2(clk_div);

  typedef enum logic {
    ARMED = 1'b0,
    DONE  = 1'b1
  } hs_state_t;

  // BCLK / frame timing
  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] bit_cnt_nxt;
  logic             div_wrap;
  logic             fall_evt;
  logic             bit_last;
  logic             frame_load;

  // handshake
  hs_state_t state;
  hs_state_t state_nxt;
  logic      read_done_nxt;
  logic      capture;
  logic      hold_free;

  // holding register and frame shift register
  logic signed [data_width-1:0] hold_p0;
  logic                         hold_vld_p0;
  logic [FRAME_BITS-1:0]        shift_p1;

  // ------------------------------------------------------------------------
  // Timing decode: a falling event is the cycle where o_bclk toggles 1 -> 0.
  // The frame reloads on the falling event that wraps bit_cnt back to 0.
  // ------------------------------------------------------------------------
  assign div_wrap    = (div_cnt == DIV_W'(clk_div - 1));
  assign fall_evt    = div_wrap && o_bclk;
  assign bit_last    = (bit_cnt == CNT_W'(FRAME_BITS - 1));
  assign bit_cnt_nxt = bit_last ? '0 : bit_cnt + 1'b1;
  assign frame_load  = fall_evt && bit_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      o_bclk  <= 1'b0;
      bit_cnt <= '0;
      o_lrclk <= 1'b0;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
      if (div_wrap) begin
        o_bclk <= ~o_bclk;
      end
      if (fall_evt) begin
        bit_cnt <= bit_cnt_nxt;
        // Lower half of the frame is the left slot.
        o_lrclk <= (bit_cnt_nxt >= CNT_W'(data_width));
      end
    end
  end

  // ------------------------------------------------------------------------
  // Capture handshake. The hold register also counts as free on the cycle a
  // frame load drains it, so a waiting producer is taken in the same cycle.
  // Re-arming only on valid low keeps a lagging valid from being captured
  // twice.
  // ------------------------------------------------------------------------
  assign hold_free = !hold_vld_p0 || frame_load;

  always_comb begin
    state_nxt     = state;
    read_done_nxt = 1'b0;
    capture       = 1'b0;
    case (state)
      ARMED: begin
        if (fx.i_data_valid && hold_free) begin
          capture       = 1'b1;
          state_nxt     = DONE;
          read_done_nxt = 1'b1;
        end
      end
      DONE: begin
        if (fx.i_data_valid) begin
          read_done_nxt = 1'b1;
        end else begin
          state_nxt = ARMED;
        end
      end
      default: begin
        state_nxt = ARMED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ARMED;
      fx.o_read_done <= 1'b0;
    end else begin
      state          <= state_nxt;
      fx.o_read_done <= read_done_nxt;
    end
  end

  // ------------------------------------------------------------------------
  // Stage p0: holding register. A capture wins over a drain in the same
  // cycle; the drain has already copied the old value into the frame.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_vld_p0 <= 1'b0;
    end else if (capture) begin
      hold_vld_p0 <= 1'b1;
    end else if (frame_load) begin
      hold_vld_p0 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      hold_p0 <= fx.i_data;
    end
  end

  // ------------------------------------------------------------------------
  // Stage p1: frame shift register, same sample in both slots. o_sdata is the
  // one-BCLK delay flop on the shift MSB, which produces the I2S data delay
  // (the right slot's LSB therefore lands in bit 0 of the following frame).
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_p1   <= '0;
      o_sdata    <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      o_underrun <= frame_load && !hold_vld_p0;
      if (fall_evt) begin
        o_sdata <= shift_p1[FRAME_BITS-1];
        if (frame_load) begin
          shift_p1 <= hold_vld_p0 ? {hold_p0, hold_p0} : '0;
        end else begin
          shift_p1 <= {shift_p1[FRAME_BITS-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// ---------------------------------------------------------------------------
// tb_i2s_tx
// Drives samples through the handshake from a vector table plus a few
// hand-written sequences. A frame model pushes the expected left/right words
// into a queue at every frame load; an I2S receiver decodes o_sdata on BCLK
// rising edges and pops/compares each word it completes.
// ---------------------------------------------------------------------------
module tb_i2s_tx;
  localparam int DW    = 16;
  localparam int CD    = 4;
  localparam int FRAME = 4 * CD * DW;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic o_bclk, o_lrclk, o_sdata, o_underrun;

  i2s_tx_if #(.data_width(DW)) fx ();

  i2s_tx #(.data_width(DW), .clk_div(CD)) dut (
    .clk        (clk),
    .reset      (reset),
    .fx         (fx),
    .o_bclk     (o_bclk),
    .o_lrclk    (o_lrclk),
    .o_sdata    (o_sdata),
    .o_underrun (o_underrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- frame model and I2S receiver -------------------------
  typedef struct {
    logic          ch;
    logic [DW-1:0] w;
  } word_t;

  word_t         exp_q[$];
  logic [DW-1:0] pend_q[$];
  logic [DW-1:0] cur_exp = '0;
  int            cyc = -1;
  int            rd_rises = 0;
  logic          prev_bclk = 1'b0;
  logic          prev_lr = 1'b0;
  logic          prev_rd = 1'b0;
  logic [DW-1:0] acc = '0;
  logic [DW-1:0] got;
  logic [DW-1:0] ld_w;
  word_t         e;
  logic          exp_unr;

  function automatic void push_frame(input logic [DW-1:0] d);
    word_t w;
    w.ch = 1'b0; w.w = d; exp_q.push_back(w);
    w.ch = 1'b1; w.w = d; exp_q.push_back(w);
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      cyc       = -1;
      prev_bclk = 1'b0;
      prev_lr   = 1'b0;
      prev_rd   = 1'b0;
      acc       = '0;
      exp_q.delete();
      pend_q.delete();
      push_frame('0);
    end else begin
      cyc++;
      // frame loads every FRAME clocks after reset release
      if (cyc > 0 && (cyc % FRAME) == 0) begin
        if (pend_q.size() > 0) begin
          ld_w = pend_q.pop_front();
          push_frame(ld_w);
          exp_unr = 1'b0;
        end else begin
          push_frame('0);
          exp_unr = 1'b1;
        end
        check("underrun_at_load", o_underrun, exp_unr);
      end else if (o_underrun) begin
        check("underrun_stray", o_underrun, 1'b0);
      end
      // a captured sample becomes eligible for loads after its capture edge
      if (fx.o_read_done && !prev_rd) begin
        rd_rises++;
        pend_q.push_back(cur_exp);
      end
      prev_rd = fx.o_read_done;
      // receiver: sample lrclk/sdata at BCLK rising edges
      if (o_bclk && !prev_bclk) begin
        check("bclk_rise_phase", cyc % (2 * CD), CD);
        if (o_lrclk != prev_lr) begin
          got = {acc[DW-2:0], o_sdata};
          if (exp_q.size() == 0) begin
            check("word_expected", 1'b0, 1'b1);
          end else begin
            e = exp_q.pop_front();
            check("slot_channel", prev_lr, e.ch);
            check(prev_lr ? "right_word" : "left_word", got, e.w);
          end
          acc = '0;
        end else begin
          acc = {acc[DW-2:0], o_sdata};
        end
        prev_lr = o_lrclk;
      end
      prev_bclk = o_bclk;
    end
  end

  // ---------------- producer ---------------------------------------------
  task automatic send(input logic [DW-1:0] d, input int lag, input bit stall, input string tag);
    int n;
    int r0;
    bit ok;
    @(posedge clk); #1;
    r0 = rd_rises;
    cur_exp = d;
    fx.i_data = d;
    fx.i_data_valid = 1'b1;
    n = 0; ok = 1'b0;
    while (!ok && n < 3 * FRAME) begin
      @(posedge clk); #2;
      n++;
      if (fx.o_read_done === 1'b1) ok = 1'b1;
    end
    check({tag, " read_done_seen"}, ok, 1'b1);
    if (!ok) begin
      fx.i_data_valid = 1'b0;
      return;
    end
    // cyc still holds the previous edge here, so the rise edge is cyc+1
    if (stall) check({tag, " rise_on_load_edge"}, (cyc + 1) % FRAME, 0);
    else       check({tag, " rise_latency"}, n, 1);
    repeat (lag) @(posedge clk);
    #1 fx.i_data_valid = 1'b0;
    n = 0; ok = 1'b0;
    while (!ok && n < 10) begin
      @(posedge clk); #2;
      n++;
      if (fx.o_read_done === 1'b0) ok = 1'b1;
    end
    check({tag, " fall_latency"}, n, 1);
    @(posedge clk); #2;
    check({tag, " single_capture"}, rd_rises - r0, 1);
  endtask

  // wait until the edge two before the next frame load
  task automatic align_to_load();
    do @(posedge clk); while (((cyc + 3) % FRAME) != 0);
  endtask

  typedef struct {
    logic [DW-1:0] data;
    int            lag;
    bit            stall;
    logic [DW-1:0] exp_w;
  } vec_t;

  vec_t vecs[7];
  int   n0;

  initial begin
    fx.i_data       = '0;
    fx.i_data_valid = 1'b0;

    vecs[0] = '{16'h8001, 2, 1'b0, 16'h8001};
    vecs[1] = '{16'h7FFF, 3, 1'b1, 16'h7FFF};
    vecs[2] = '{16'h0000, 2, 1'b1, 16'h0000};
    vecs[3] = '{16'h1234, 4, 1'b1, 16'h1234};
    vecs[4] = '{16'hFFFF, 5, 1'b1, 16'hFFFF};
    vecs[5] = '{16'h5A5A, 2, 1'b1, 16'h5A5A};
    vecs[6] = '{16'h8000, 3, 1'b1, 16'h8000};

    // reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_bclk", o_bclk, 1'b0);
    check("rst_lrclk", o_lrclk, 1'b0);
    check("rst_sdata", o_sdata, 1'b0);
    check("rst_read_done", fx.o_read_done, 1'b0);
    check("rst_underrun", o_underrun, 1'b0);
    @(posedge clk); #1 reset = 1'b0;

    // table: first sample goes straight in, the rest wait for a frame load
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].data, vecs[i].lag, vecs[i].stall, $sformatf("vec%0d", i));
    end

    // starvation: last sample drains, then two empty frames
    repeat (3 * FRAME) @(posedge clk);
    send(16'hC3A5, 2, 1'b0, "late");

    // capture on the load edge with hold full, then with hold empty
    align_to_load();
    send(16'h0F0F, 2, 1'b1, "load_full");
    repeat (FRAME) @(posedge clk);
    align_to_load();
    send(16'hF0F0, 3, 1'b1, "load_empty");
    repeat (2 * FRAME) @(posedge clk);

    // reset while DONE: held sample must never reach o_sdata
    @(posedge clk); #1;
    n0 = rd_rises;
    cur_exp = 16'h6666;
    fx.i_data = 16'h6666;
    fx.i_data_valid = 1'b1;
    repeat (4) @(posedge clk);
    #2 check("mid_rst_done_before", fx.o_read_done, 1'b1);
    #1;
    reset = 1'b1;
    fx.i_data_valid = 1'b0;
    @(posedge clk); #2;
    check("mid_rst_read_done", fx.o_read_done, 1'b0);
    check("mid_rst_sdata", o_sdata, 1'b0);
    check("mid_rst_bclk", o_bclk, 1'b0);
    check("mid_rst_lrclk", o_lrclk, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (2 * FRAME + 4 * CD * 2) @(posedge clk);
    check("mid_rst_captures", rd_rises - n0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Output stage of the audio chain: consumes mono signed samples from the effect stage over a valid/read_done 4-phase handshake and serializes each one to an I2S DAC. Each sample is transmitted on both the left and right channels of a frame. One holding register decouples the effect handshake from frame timing. The block generates BCLK and LRCLK from the system clock.

## Interface
- data_width, 16: sample width in bits; also the slot width per channel (frame = 2*data_width BCLKs).
- clk_div, 4: system clocks per BCLK half-period; must be >= 2.
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- i_data  input  data_width  signed sample from the effect stage; stable while i_data_valid=1.
- i_data_valid  input  1  sample available; held high by the producer until it sees o_read_done.
- o_read_done  output  1  sample captured; held high until i_data_valid is seen low.
- o_bclk  output  1  I2S bit clock.
- o_lrclk  output  1  I2S word select: 0 = left, 1 = right.
- o_sdata  output  1  I2S serial data, MSB first, two's complement.
- o_underrun  output  1  one-cycle pulse when a frame loads with no sample held.

## Operation
- Reset values: o_bclk=0, o_lrclk=0, o_sdata=0, o_read_done=0, o_underrun=0, hold empty, handshake armed, div_cnt=0, bit_cnt=0, shift register=0, delay flop=0.
- Capture handshake (states ARMED, DONE):
  - ARMED: if i_data_valid=1 and hold empty, latch i_data into hold, set hold full, and go to DONE.
  - DONE: o_read_done=1. Stay in DONE while i_data_valid=1. On the first cycle i_data_valid=0, drop o_read_done and return to ARMED.
  - The producer's valid lags read_done by 2+ cycles. It must never cause a second capture of the same sample, which is guaranteed by the re-arm on valid low.
  - If hold is full, valid is not acknowledged. o_read_done stays 0 and the producer stalls.
- BCLK generator: div_cnt counts 0..clk_div-1. At clk_div-1 it wraps and o_bclk toggles. A toggle from 1 to 0 is a falling event.
- Bit counter: bit_cnt (log2(2*data_width) bits) increments on each falling event and wraps at 2*data_width-1 to 0.
- Frame load: on the falling event where bit_cnt wraps to 0:
  - If hold is full, the shift register loads {hold, hold} and hold becomes empty.
  - If hold is empty, the shift register loads all zeros and o_underrun pulses for 1 cycle.
- Shifting: on every other falling event, the shift register shifts left by 1 (zero fill).
- Serial output, applied on every falling event:
  - o_sdata is driven from a delay flop holding the previous shift-register MSB. This gives the standard I2S one-BCLK delay: the MSB of each channel appears in the second BCLK after the LRCLK edge.
  - The right channel's LSB is output during bit 0 of the next frame.
- o_lrclk = bit_cnt MSB, registered on the falling event (0 for bits 0..data_width-1, 1 for the rest).
- Simultaneous events:
  - Frame load and capture in the same cycle with hold full: the load takes the old hold value, the capture writes the new value, and hold stays full.
  - Frame load and capture in the same cycle with hold empty: the load sends zeros and flags underrun, and the capture still fills hold.
- Reset mid-frame or mid-handshake: everything returns to reset values next cycle, the held sample is discarded, and o_read_done drops. The producer, reset together with this block, restarts at idle.

## Timing
- BCLK period = 2*clk_div clocks. Frame = 2*data_width BCLKs = 4*clk_div*data_width clocks. The default is 256 clocks per sample.
- All outputs are registered. o_sdata and o_lrclk change only on the clock edge where o_bclk goes 1->0, so they are stable at the DAC's BCLK rising edge.
- Capture latency: o_read_done rises 1 cycle after the first cycle with i_data_valid=1, ARMED and hold empty. It falls 1 cycle after i_data_valid is seen 0.
- Sample-to-pin latency: the MSB appears on o_sdata 1 BCLK after the next frame load. The first frame load occurs 2*data_width falling events after reset release.
- Throughput: 1 sample per frame. Hold plus shift register buffer up to 2 samples.

## Test plan
- Reset: hold reset 3 cycles -> every output 0. First o_bclk rise at clk_div=4 cycles after release, period 8.
- Single sample 16'h8001, valid held until read_done:
  - o_read_done rises 1 cycle after valid and falls 1 cycle after valid drops.
  - The next frame serializes 1000_0000_0000_0001 in both left and right slots, each MSB 1 BCLK after its LRCLK edge.
- Lagging valid: valid stays high 3 cycles after read_done -> exactly one capture, and only one frame carries the sample.
- Back-to-back samples 16'h7FFF then 16'h0000: the second sample stalls with read_done low until the frame load empties hold. Consecutive frames carry 7FFF then 0000 with no underrun.
- Starvation: no valid for 2 frames -> zeros on o_sdata and one o_underrun pulse per frame load. A late sample appears in the next frame.
- Reset mid-frame while DONE: o_read_done and o_sdata go to 0 next cycle, and the held sample never appears on o_sdata.
